// File: rtl/rv_shifter_arb.sv
// Two-port arbiter in front of a fixed-latency shifter, with a shared result register.
// Define URV_SHIFTER_ARB_RR_EN to alternate ties between the ports; otherwise port A wins every tie.
module rv_shifter_arb #(
  parameter int unsigned SH_LATENCY = 1
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        flush_i,
  input  logic        a_valid_i,
  input  logic        b_valid_i,
  output logic        a_ready_o,
  output logic        b_ready_o,
  input  logic [31:0] a_rs1_i,
  input  logic [31:0] b_rs1_i,
  input  logic [4:0]  a_shamt_i,
  input  logic [4:0]  b_shamt_i,
  input  logic [2:0]  a_fun_i,
  input  logic [2:0]  b_fun_i,
  input  logic        a_sign_i,
  input  logic        b_sign_i,
  output logic        a_rsp_valid_o,
  output logic        b_rsp_valid_o,
  input  logic        a_rsp_ready_i,
  input  logic        b_rsp_ready_i,
  output logic [31:0] rsp_data_o,
  output logic        sh_valid_o,
  output logic [31:0] sh_rs1_o,
  output logic [4:0]  sh_shamt_o,
  output logic [2:0]  sh_fun_o,
  output logic        sh_sign_o,
  input  logic [31:0] sh_rd_i
);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_e;

  state_e      state_q;
  logic [1:0]  cnt_q;
  logic        owner_b_q;
  logic [31:0] result_q;
`ifdef URV_SHIFTER_ARB_RR_EN
  logic        last_b_q;
`endif

  logic owner_ready;
  logic accept;
  logic grant;
  logic win_b;

  // Grant is gated by rst_n_i so every output is zero while reset is held.
  always_comb begin
    owner_ready = owner_b_q ? b_rsp_ready_i : a_rsp_ready_i;
    accept      = (state_q == RESP) && owner_ready && !flush_i;
    grant       = rst_n_i && !flush_i && (a_valid_i || b_valid_i) &&
                  ((state_q == IDLE) || accept);
`ifdef URV_SHIFTER_ARB_RR_EN
    win_b       = b_valid_i && (!a_valid_i || !last_b_q);
`else
    win_b       = b_valid_i && !a_valid_i;
`endif
  end

  assign sh_valid_o    = grant;
  assign a_ready_o     = grant && !win_b;
  assign b_ready_o     = grant && win_b;
  assign sh_rs1_o      = !grant ? '0 : (win_b ? b_rs1_i   : a_rs1_i);
  assign sh_shamt_o    = !grant ? '0 : (win_b ? b_shamt_i : a_shamt_i);
  assign sh_fun_o      = !grant ? '0 : (win_b ? b_fun_i   : a_fun_i);
  assign sh_sign_o     = grant && (win_b ? b_sign_i : a_sign_i);
  assign a_rsp_valid_o = (state_q == RESP) && !owner_b_q;
  assign b_rsp_valid_o = (state_q == RESP) && owner_b_q;
  assign rsp_data_o    = (state_q == RESP) ? result_q : '0;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      owner_b_q <= 1'b0;
      result_q  <= '0;
`ifdef URV_SHIFTER_ARB_RR_EN
      last_b_q  <= 1'b1;
`endif
    end else if (flush_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else if (grant) begin
      state_q   <= BUSY;
      cnt_q     <= 2'(SH_LATENCY);
      owner_b_q <= win_b;
`ifdef URV_SHIFTER_ARB_RR_EN
      last_b_q  <= win_b;
`endif
    end else begin
      case (state_q)
        BUSY: begin
          if (cnt_q == 2'd1) begin
            result_q <= sh_rd_i;
            cnt_q    <= '0;
            state_q  <= RESP;
          end else begin
            cnt_q <= cnt_q - 2'd1;
          end
        end
        RESP: begin
          if (accept) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rv_shifter_arb.sv
// Scenario bench for rv_shifter_arb: a reference shifter on the sh_* side, a handshake
// model with a result scoreboard, and one task per scenario with its own inline checks.
module tb_rv_shifter_arb;
  localparam int unsigned LAT = 1;
  localparam logic [2:0] FUNC_SL = 3'b001;
  localparam logic [2:0] FUNC_SR = 3'b101;
`ifdef URV_SHIFTER_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n_i, flush_i;
  logic        a_valid_i, b_valid_i, a_ready_o, b_ready_o;
  logic [31:0] a_rs1_i, b_rs1_i;
  logic [4:0]  a_shamt_i, b_shamt_i;
  logic [2:0]  a_fun_i, b_fun_i;
  logic        a_sign_i, b_sign_i;
  logic        a_rsp_valid_o, b_rsp_valid_o, a_rsp_ready_i, b_rsp_ready_i;
  logic [31:0] rsp_data_o;
  logic        sh_valid_o;
  logic [31:0] sh_rs1_o;
  logic [4:0]  sh_shamt_o;
  logic [2:0]  sh_fun_o;
  logic        sh_sign_o;
  logic [31:0] sh_rd_i = '0;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  rv_shifter_arb #(.SH_LATENCY(LAT)) dut (
    .clk_i(clk), .rst_n_i(rst_n_i), .flush_i(flush_i),
    .a_valid_i(a_valid_i), .b_valid_i(b_valid_i),
    .a_ready_o(a_ready_o), .b_ready_o(b_ready_o),
    .a_rs1_i(a_rs1_i), .b_rs1_i(b_rs1_i),
    .a_shamt_i(a_shamt_i), .b_shamt_i(b_shamt_i),
    .a_fun_i(a_fun_i), .b_fun_i(b_fun_i),
    .a_sign_i(a_sign_i), .b_sign_i(b_sign_i),
    .a_rsp_valid_o(a_rsp_valid_o), .b_rsp_valid_o(b_rsp_valid_o),
    .a_rsp_ready_i(a_rsp_ready_i), .b_rsp_ready_i(b_rsp_ready_i),
    .rsp_data_o(rsp_data_o),
    .sh_valid_o(sh_valid_o), .sh_rs1_o(sh_rs1_o), .sh_shamt_o(sh_shamt_o),
    .sh_fun_o(sh_fun_o), .sh_sign_o(sh_sign_o), .sh_rd_i(sh_rd_i)
  );

  function automatic logic [31:0] shift_ref(input logic [31:0] v, input logic [4:0] s,
                                            input logic [2:0] f, input logic sg);
    if (f == FUNC_SL) return v << s;
    else if (sg)      return 32'($signed(v) >>> s);
    else              return v >> s;
  endfunction

  // Shifter stand-in: result stays valid until the next issue.
  always @(negedge clk)
    if (sh_valid_o) sh_rd_i <= shift_ref(sh_rs1_o, sh_shamt_o, sh_fun_o, sh_sign_o);

  typedef struct { logic b; logic [31:0] d; } exp_t;
  exp_t        q[$];
  int          m_phase;   // 0 idle, 1 busy, 2 resp
  int unsigned m_cnt;
  logic        m_owner_b, m_last_b;

  always @(negedge clk) begin : mon
    logic acc, gnt, wb, wsg;
    logic [31:0] wrs1, exp_data;
    logic [4:0]  wsh;
    logic [2:0]  wfun;
    logic [4:0]  hs_exp, hs_got;
    logic [40:0] op_exp, op_got;
    if (!rst_n_i) begin
      n_checks++;
      if ({sh_valid_o, a_ready_o, b_ready_o, a_rsp_valid_o, b_rsp_valid_o, sh_sign_o} !== '0 ||
          rsp_data_o !== '0 || sh_rs1_o !== '0 || sh_shamt_o !== '0 || sh_fun_o !== '0)
        $display("FAIL mon_reset_outputs: got hs=%b data=%h rs1=%h want all zero",
                 {sh_valid_o, a_ready_o, b_ready_o, a_rsp_valid_o, b_rsp_valid_o}, rsp_data_o, sh_rs1_o);
      else n_pass++;
      m_phase = 0; m_cnt = 0; m_owner_b = 1'b0; m_last_b = 1'b1;
      q.delete();
    end else begin
      acc  = (m_phase == 2) && (m_owner_b ? b_rsp_ready_i : a_rsp_ready_i) && !flush_i;
      gnt  = !flush_i && (a_valid_i || b_valid_i) && (m_phase == 0 || acc);
      wb   = b_valid_i && (!a_valid_i || (RR && !m_last_b));
      wrs1 = wb ? b_rs1_i : a_rs1_i;
      wsh  = wb ? b_shamt_i : a_shamt_i;
      wfun = wb ? b_fun_i : a_fun_i;
      wsg  = wb ? b_sign_i : a_sign_i;
      exp_data = (m_phase == 2 && q.size() > 0) ? q[0].d : '0;

      hs_exp = {gnt, gnt && !wb, gnt && wb, m_phase == 2 && !m_owner_b, m_phase == 2 && m_owner_b};
      hs_got = {sh_valid_o, a_ready_o, b_ready_o, a_rsp_valid_o, b_rsp_valid_o};
      n_checks++;
      if (hs_got !== hs_exp)
        $display("FAIL mon_handshake t=%0t: got %b want %b (sh_v,a_rdy,b_rdy,a_rv,b_rv)", $time, hs_got, hs_exp);
      else n_pass++;

      n_checks++;
      if (rsp_data_o !== exp_data)
        $display("FAIL mon_rsp_data t=%0t: got %h want %h", $time, rsp_data_o, exp_data);
      else n_pass++;

      op_exp = gnt ? {wrs1, wsh, wfun, wsg} : '0;
      op_got = {sh_rs1_o, sh_shamt_o, sh_fun_o, sh_sign_o};
      n_checks++;
      if (op_got !== op_exp)
        $display("FAIL mon_sh_operands t=%0t: got %h want %h", $time, op_got, op_exp);
      else n_pass++;

      if (flush_i) begin
        if (m_phase != 0 && q.size() > 0) void'(q.pop_front());
        m_phase = 0;
      end else begin
        if (acc && q.size() > 0) void'(q.pop_front());
        if (gnt) begin
          q.push_back('{wb, shift_ref(wrs1, wsh, wfun, wsg)});
          m_phase = 1; m_cnt = LAT; m_owner_b = wb; m_last_b = wb;
        end else if (acc) begin
          m_phase = 0;
        end else if (m_phase == 1) begin
          if (m_cnt == 1) m_phase = 2;
          else m_cnt--;
        end
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  task automatic drain(input int n);
    a_valid_i = 0; b_valid_i = 0; flush_i = 0;
    a_rsp_ready_i = 1; b_rsp_ready_i = 1;
    repeat (n) next_cycle();
  endtask

  task automatic apply_reset();
    next_cycle();
    rst_n_i = 0;
    drain(2);
    rst_n_i = 1;
  endtask

  task automatic test_reset();
    rst_n_i = 0; a_valid_i = 1; b_valid_i = 1;
    a_rs1_i = 32'h1234_5678; b_rs1_i = 32'h8765_4321;
    a_shamt_i = 5'd3; b_shamt_i = 5'd7; a_fun_i = FUNC_SL; b_fun_i = FUNC_SR;
    a_sign_i = 1; b_sign_i = 1; a_rsp_ready_i = 1; b_rsp_ready_i = 1;
    next_cycle(); next_cycle();
    @(negedge clk);
    n_checks++;
    if ({sh_valid_o, a_ready_o, b_ready_o, a_rsp_valid_o, b_rsp_valid_o} !== 5'b0 || rsp_data_o !== '0)
      $display("FAIL reset_outputs: got hs=%b data=%h want 0",
               {sh_valid_o, a_ready_o, b_ready_o, a_rsp_valid_o, b_rsp_valid_o}, rsp_data_o);
    else n_pass++;
    next_cycle();
    rst_n_i = 1;
    @(negedge clk);
    n_checks++;
    if ({sh_valid_o, a_ready_o, b_ready_o} !== 3'b110)
      $display("FAIL reset_first_grant: got sh_v,a_rdy,b_rdy=%b want 110", {sh_valid_o, a_ready_o, b_ready_o});
    else n_pass++;
    next_cycle();
    drain(3);
  endtask

  task automatic test_a_only();
    a_valid_i = 1; a_rs1_i = 32'h8000_0000; a_shamt_i = 5'd4; a_fun_i = FUNC_SR; a_sign_i = 1;
    a_rsp_ready_i = 1;
    @(negedge clk);
    n_checks++;
    if ({sh_valid_o, a_ready_o} !== 2'b11 || sh_rs1_o !== 32'h8000_0000)
      $display("FAIL a_only_issue: got sh_v,a_rdy=%b rs1=%h want 11 80000000", {sh_valid_o, a_ready_o}, sh_rs1_o);
    else n_pass++;
    next_cycle();
    a_valid_i = 0; a_rs1_i = 32'hDEAD_BEEF; a_shamt_i = 5'd1; a_sign_i = 0;
    @(negedge clk);
    n_checks++;
    if (a_rsp_valid_o !== 1'b0) $display("FAIL a_only_early_rsp: got %b want 0", a_rsp_valid_o);
    else n_pass++;
    next_cycle();
    @(negedge clk);
    n_checks++;
    if (a_rsp_valid_o !== 1'b1 || rsp_data_o !== 32'hF800_0000)
      $display("FAIL a_only_rsp: got valid=%b data=%h want 1 f8000000", a_rsp_valid_o, rsp_data_o);
    else n_pass++;
    next_cycle();
    @(negedge clk);
    n_checks++;
    if (a_rsp_valid_o !== 1'b0 || rsp_data_o !== '0)
      $display("FAIL a_only_after_accept: got valid=%b data=%h want 0 0", a_rsp_valid_o, rsp_data_o);
    else n_pass++;
    drain(2);
  endtask

  task automatic test_tie();
    logic gb[$];
    int   gi[$];
    apply_reset();
    a_valid_i = 1; b_valid_i = 1; a_rsp_ready_i = 1; b_rsp_ready_i = 1;
    for (int i = 0; i < 4 * int'(LAT + 1); i++) begin
      a_rs1_i = $urandom; b_rs1_i = $urandom;
      a_shamt_i = 5'($urandom_range(0, 31)); b_shamt_i = 5'($urandom_range(0, 31));
      a_fun_i = (i % 2 == 0) ? FUNC_SL : FUNC_SR; b_fun_i = FUNC_SR;
      a_sign_i = 1'(i % 3 == 0); b_sign_i = 1'(i % 2);
      @(negedge clk);
      if (sh_valid_o) begin gb.push_back(b_ready_o); gi.push_back(i); end
      next_cycle();
    end
    n_checks++;
    if (gb.size() != 4) $display("FAIL tie_grant_count: got %0d want 4", gb.size());
    else n_pass++;
    for (int k = 0; k < 4 && k < gb.size(); k++) begin
      n_checks++;
      if (gb[k] !== (RR ? 1'(k % 2) : 1'b0) || gi[k] != k * int'(LAT + 1))
        $display("FAIL tie_grant_%0d: got port_b=%b cycle=%0d want port_b=%b cycle=%0d",
                 k, gb[k], gi[k], RR ? 1'(k % 2) : 1'b0, k * int'(LAT + 1));
      else n_pass++;
    end
    drain(LAT + 3);
  endtask

  task automatic test_backpressure();
    logic [31:0] exp;
    b_valid_i = 1; b_rs1_i = 32'hF0F0_1234; b_shamt_i = 5'd8; b_fun_i = FUNC_SR; b_sign_i = 1;
    b_rsp_ready_i = 0; a_valid_i = 0; a_rsp_ready_i = 1;
    exp = shift_ref(32'hF0F0_1234, 5'd8, FUNC_SR, 1'b1);
    @(negedge clk);
    n_checks++;
    if (b_ready_o !== 1'b1) $display("FAIL bp_b_grant: got %b want 1", b_ready_o);
    else n_pass++;
    next_cycle();
    b_valid_i = 0; a_valid_i = 1; a_rs1_i = 32'h0000_00FF; a_shamt_i = 5'd4; a_fun_i = FUNC_SL; a_sign_i = 0;
    repeat (LAT) next_cycle();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_checks++;
      if (b_rsp_valid_o !== 1'b1 || rsp_data_o !== exp || a_ready_o !== 1'b0)
        $display("FAIL bp_hold_%0d: got b_rv=%b data=%h a_rdy=%b want 1 %h 0", i, b_rsp_valid_o, rsp_data_o, a_ready_o, exp);
      else n_pass++;
      next_cycle();
    end
    b_rsp_ready_i = 1;
    @(negedge clk);
    n_checks++;
    if (a_ready_o !== 1'b1 || sh_valid_o !== 1'b1)
      $display("FAIL bp_release_grant: got a_rdy=%b sh_v=%b want 1 1", a_ready_o, sh_valid_o);
    else n_pass++;
    next_cycle();
    drain(LAT + 3);
  endtask

  task automatic test_flush();
    a_valid_i = 1; a_rs1_i = 32'h0000_1000; a_shamt_i = 5'd2; a_fun_i = FUNC_SL; a_sign_i = 0;
    a_rsp_ready_i = 1; b_rsp_ready_i = 1;
    next_cycle();
    a_valid_i = 0; flush_i = 1;
    next_cycle();
    flush_i = 0;
    b_valid_i = 1; b_rs1_i = 32'h8000_0010; b_shamt_i = 5'd1; b_fun_i = FUNC_SR; b_sign_i = 0;
    @(negedge clk);
    n_checks++;
    if (b_ready_o !== 1'b1 || a_rsp_valid_o !== 1'b0 || b_rsp_valid_o !== 1'b0)
      $display("FAIL flush_busy_then_grant: got b_rdy=%b a_rv=%b b_rv=%b want 1 0 0", b_ready_o, a_rsp_valid_o, b_rsp_valid_o);
    else n_pass++;
    next_cycle();
    b_valid_i = 0;
    repeat (LAT) next_cycle();
    @(negedge clk);
    n_checks++;
    if (b_rsp_valid_o !== 1'b1 || rsp_data_o !== 32'h4000_0008 || a_rsp_valid_o !== 1'b0)
      $display("FAIL flush_next_rsp: got b_rv=%b data=%h a_rv=%b want 1 40000008 0", b_rsp_valid_o, rsp_data_o, a_rsp_valid_o);
    else n_pass++;
    drain(2);
    // flush arriving together with rsp_ready in RESP drops the result and blocks a grant
    a_valid_i = 1; a_rs1_i = 32'h0000_0003; a_shamt_i = 5'd1;
    next_cycle();
    a_valid_i = 0;
    repeat (LAT) next_cycle();
    flush_i = 1; b_valid_i = 1;
    @(negedge clk);
    n_checks++;
    if (sh_valid_o !== 1'b0 || b_ready_o !== 1'b0)
      $display("FAIL flush_resp_no_grant: got sh_v=%b b_rdy=%b want 0 0", sh_valid_o, b_ready_o);
    else n_pass++;
    next_cycle();
    flush_i = 0; b_valid_i = 0;
    @(negedge clk);
    n_checks++;
    if (a_rsp_valid_o !== 1'b0 || rsp_data_o !== '0)
      $display("FAIL flush_resp_dropped: got a_rv=%b data=%h want 0 0", a_rsp_valid_o, rsp_data_o);
    else n_pass++;
    drain(2);
  endtask

  task automatic test_reset_in_resp();
    a_valid_i = 1; a_rs1_i = 32'h0000_0055; a_shamt_i = 5'd0; a_fun_i = FUNC_SL; a_sign_i = 0;
    a_rsp_ready_i = 0;
    next_cycle();
    a_valid_i = 0;
    repeat (LAT) next_cycle();
    n_checks++;
    if (a_rsp_valid_o !== 1'b1) $display("FAIL rst_resp_reached: got %b want 1", a_rsp_valid_o);
    else n_pass++;
    a_valid_i = 1; b_valid_i = 1; a_rsp_ready_i = 1;
    #1 rst_n_i = 0;
    #1;
    n_checks++;
    if ({sh_valid_o, a_ready_o, b_ready_o, a_rsp_valid_o, b_rsp_valid_o} !== 5'b0 || rsp_data_o !== '0)
      $display("FAIL rst_async_clear: got hs=%b data=%h want 0",
               {sh_valid_o, a_ready_o, b_ready_o, a_rsp_valid_o, b_rsp_valid_o}, rsp_data_o);
    else n_pass++;
    next_cycle(); next_cycle();
    rst_n_i = 1;
    @(negedge clk);
    n_checks++;
    if ({a_ready_o, b_ready_o} !== 2'b10)
      $display("FAIL rst_first_tie: got a_rdy,b_rdy=%b want 10", {a_ready_o, b_ready_o});
    else n_pass++;
    next_cycle();
    drain(LAT + 3);
  endtask

  initial begin
    flush_i = 0;
    test_reset();
    test_a_only();
    test_tie();
    test_backpressure();
    test_flush();
    test_reset_in_resp();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish want finish");
    $fatal(1, "timeout");
  end

endmodule
